// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receive path (and the future TX side).
// Optional parity support is selected with the SERIAL_RX_PARITY_EN macro in serial_rx.
package serial_pkg;

  localparam int SERIAL_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage : serial_pkg

// File: rtl/serial_rx_if.sv
// Strobe-only receive interface toward pinwheel. There is no ready signal because pinwheel has no backpressure.
interface serial_rx_if;
  import serial_pkg::*;

  logic                        serial_valid;
  logic [SERIAL_DATA_BITS-1:0] serial_data;
  logic                        frame_error;
  logic                        parity_error;
  logic                        busy;

  modport master (
    output serial_valid,
    output serial_data,
    output frame_error,
    output parity_error,
    output busy
  );

  modport slave (
    input serial_valid,
    input serial_data,
    input frame_error,
    input parity_error,
    input busy
  );

endinterface : serial_rx_if

// File: rtl/serial_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// reset_value sets the level both flops take in reset, so the line can look idle at that level.
module serial_sync #(
  parameter logic reset_value = 1'b1
) (
  input  logic clock,
  input  logic reset_in,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      meta <= reset_value;
      q    <= reset_value;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : serial_sync

// File: rtl/serial_rx.sv
// 8N1 UART receiver with oversampling, framing-error and start-glitch detection.
// Define SERIAL_RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module serial_rx
  import serial_pkg::*;
#(
  parameter int cycles_per_bit = 16,
  parameter int parity_odd     = 0
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic        rx_in,
  serial_rx_if.master serial
);

  localparam int                CNT_W     = $clog2(cycles_per_bit);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(cycles_per_bit / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(cycles_per_bit - 1);
  localparam logic [2:0]        LAST_IDX  = 3'(SERIAL_DATA_BITS - 1);

  generate
    if (cycles_per_bit < 4 || (cycles_per_bit % 2) != 0 || parity_odd < 0 || parity_odd > 1)
    begin : g_bad_cfg
      $error("serial_rx: cycles_per_bit must be even and >= 4, parity_odd must be 0 or 1");
    end
  endgenerate

  logic                        rx_s;
  rx_state_t                   state;
  logic [CNT_W-1:0]            cnt;
  logic [2:0]                  bit_idx;
  logic [SERIAL_DATA_BITS-1:0] shift;
  logic                        valid_q;
  logic [SERIAL_DATA_BITS-1:0] data_q;
  logic                        frame_err_q;

  serial_sync #(
    .reset_value(1'b1)
  ) u_sync (
    .clock   (clock),
    .reset_in(reset_in),
    .d       (rx_in),
    .q       (rx_s)
  );

`ifdef SERIAL_RX_PARITY_EN
  localparam logic PARITY_SENSE = 1'(parity_odd);
  logic par_bad;
  logic par_err_q;
`endif

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad     <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end

        // Mid-start-bit check rejects pulses shorter than half a bit.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[SERIAL_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= rx_s != ((^shift) ^ PARITY_SENSE);
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        // Framing error wins over parity error; either way serial_data keeps the last good byte.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
`ifdef SERIAL_RX_PARITY_EN
              if (par_bad) begin
                par_err_q <= 1'b1;
              end else begin
                valid_q <= 1'b1;
                data_q  <= shift;
              end
`else
              valid_q <= 1'b1;
              data_q  <= shift;
`endif
              state <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign serial.serial_valid = valid_q;
  assign serial.serial_data  = data_q;
  assign serial.frame_error  = frame_err_q;
  assign serial.busy         = (state != IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign serial.parity_error = par_err_q;
`else
  assign serial.parity_error = 1'b0;
`endif

endmodule : serial_rx

// File: tb/tb_serial_rx.sv
// Directed testbench for serial_rx: reset abort, latency, glitch rejection, framing error, back-to-back frames.
module tb_serial_rx;

  localparam int CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LATENCY = 2 + CPB / 2 + (NBITS - 1) * CPB;

  logic clock    = 1'b0;
  logic reset_in = 1'b1;
  logic rx_in    = 1'b1;

  serial_rx_if sif ();

  serial_rx #(
    .cycles_per_bit(CPB),
    .parity_odd    (0)
  ) dut (
    .clock   (clock),
    .reset_in(reset_in),
    .rx_in   (rx_in),
    .serial  (sif)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Passive monitor of the strobe outputs, sampled on the falling edge.
  int         n_valid = 0, n_fe = 0, n_pe = 0, n_long = 0, n_multi = 0;
  int         last_valid_cyc = 0, prev_valid_cyc = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;
  logic       was_valid = 1'b0;
  int         frame_start = 0;

  always @(negedge clock) begin
    if (sif.serial_valid) begin
      n_valid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      prev_data      = last_data;
      last_data      = sif.serial_data;
      if (was_valid) n_long++;
    end
    was_valid = sif.serial_valid;
    if (sif.frame_error)  n_fe++;
    if (sif.parity_error) n_pe++;
    if ((32'(sif.serial_valid) + 32'(sif.frame_error) + 32'(sif.parity_error)) > 1) n_multi++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    frame_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit) rx_in = 1'b1;
`endif
    drive_bit(stop_bit);
    rx_in = 1'b1;
  endtask

  task automatic test_reset;
    int v0, f0, p0;
    wait_cycles(3);
    n_checks++;
    if ({sif.serial_valid, sif.frame_error, sif.parity_error, sif.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0000", {sif.serial_valid, sif.frame_error, sif.parity_error, sif.busy});
    end
    n_checks++;
    if (sif.serial_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 00", sif.serial_data);
    end
    reset_in = 1'b0;
    wait_cycles(5);
    v0 = n_valid; f0 = n_fe; p0 = n_pe;
    // 0x5A LSB first: 0,1,0,1 then abort
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    n_checks++;
    if (sif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy_midframe: got %b want 1", sif.busy);
    end
    reset_in = 1'b1;
    #1;
    n_checks++;
    if (sif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_busy: got %b want 0", sif.busy);
    end
    rx_in = 1'b1;
    wait_cycles(3);
    reset_in = 1'b0;
    wait_cycles(20);
    n_checks++;
    if ((n_valid - v0) + (n_fe - f0) + (n_pe - p0) !== 0) begin
      n_fail++;
      $display("FAIL reset_abort_strobes: got %0d strobes want 0", (n_valid - v0) + (n_fe - f0) + (n_pe - p0));
    end
    send_frame(8'h5A, ^8'h5A, 1'b1);
    n_checks++;
    if (n_valid - v0 !== 1 || last_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_then_5a: got %0d strobes data %h want 1 strobe data 5a", n_valid - v0, last_data);
    end
  endtask

  task automatic test_latency;
    int v0;
    wait_cycles(10);
    v0 = n_valid;
    send_frame(8'h55, ^8'h55, 1'b1);
    n_checks++;
    if (n_valid - v0 !== 1) begin
      n_fail++;
      $display("FAIL latency_count: got %0d strobes want 1", n_valid - v0);
    end
    n_checks++;
    if (last_valid_cyc - frame_start - 1 !== LATENCY) begin
      n_fail++;
      $display("FAIL latency_cycles: got %0d want %0d", last_valid_cyc - frame_start - 1, LATENCY);
    end
    n_checks++;
    if (last_data !== 8'h55) begin
      n_fail++;
      $display("FAIL latency_data: got %h want 55", last_data);
    end
    wait_cycles(50);
    n_checks++;
    if (sif.serial_data !== 8'h55 || sif.serial_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_hold: got data %h valid %b want 55 0", sif.serial_data, sif.serial_valid);
    end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = n_valid; f0 = n_fe;
    rx_in = 1'b0;
    wait_cycles(5);
    rx_in = 1'b1;
    wait_cycles(5);
    n_checks++;
    if (sif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_start: got %b want 1", sif.busy);
    end
    wait_cycles(1);
    n_checks++;
    if (sif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy_idle: got %b want 0", sif.busy);
    end
    wait_cycles(30);
    n_checks++;
    if (n_valid !== v0 || n_fe !== f0 || sif.serial_data !== 8'h55) begin
      n_fail++;
      $display("FAIL glitch_no_strobe: got valid %0d fe %0d data %h want 0 0 55", n_valid - v0, n_fe - f0, sif.serial_data);
    end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = n_valid; f0 = n_fe;
    send_frame(8'hA3, ^8'hA3, 1'b0);
    rx_in = 1'b0;
    wait_cycles(40);
    n_checks++;
    if (n_fe - f0 !== 1 || n_valid !== v0) begin
      n_fail++;
      $display("FAIL frame_error_count: got fe %0d valid %0d want 1 0", n_fe - f0, n_valid - v0);
    end
    n_checks++;
    if (sif.serial_data !== 8'h55 || sif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_error_hold: got data %h busy %b want 55 1", sif.serial_data, sif.busy);
    end
    rx_in = 1'b1;
    wait_cycles(10);
    n_checks++;
    if (sif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_error_release: got busy %b want 0", sif.busy);
    end
    send_frame(8'h3C, ^8'h3C, 1'b1);
    n_checks++;
    if (n_valid - v0 !== 1 || last_data !== 8'h3C || n_fe - f0 !== 1) begin
      n_fail++;
      $display("FAIL frame_error_recover: got valid %0d data %h fe %0d want 1 3c 1", n_valid - v0, last_data, n_fe - f0);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    wait_cycles(5);
    v0 = n_valid;
    send_frame(8'h00, ^8'h00, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    n_checks++;
    if (n_valid - v0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 2", n_valid - v0);
    end
    n_checks++;
    if (prev_data !== 8'h00 || last_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_data: got %h %h want 00 ff", prev_data, last_data);
    end
    n_checks++;
    if (last_valid_cyc - prev_valid_cyc !== NBITS * CPB) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d want %0d", last_valid_cyc - prev_valid_cyc, NBITS * CPB);
    end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    wait_cycles(5);
    v0 = n_valid; p0 = n_pe;
    send_frame(8'h07, 1'b1, 1'b1);
    n_checks++;
    if (n_valid - v0 !== 1 || last_data !== 8'h07 || n_pe !== p0) begin
      n_fail++;
      $display("FAIL parity_good: got valid %0d data %h pe %0d want 1 07 0", n_valid - v0, last_data, n_pe - p0);
    end
    send_frame(8'h07, 1'b0, 1'b1);
    n_checks++;
    if (n_pe - p0 !== 1 || n_valid - v0 !== 1 || sif.serial_data !== 8'h07) begin
      n_fail++;
      $display("FAIL parity_bad: got pe %0d valid %0d data %h want 1 1 07", n_pe - p0, n_valid - v0, sif.serial_data);
    end
  endtask
`endif

  task automatic test_global;
    n_checks++;
    if (n_long !== 0 || n_multi !== 0) begin
      n_fail++;
      $display("FAIL strobe_shape: got long %0d multi %0d want 0 0", n_long, n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_frame_error();
    test_back_to_back();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    test_global();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_rx
